// File: rtl/rect_draw_pkg.sv
// Shared types and default geometry for the rectangle plotting engine.
package rect_draw_pkg;

  localparam int unsigned DEF_X_W        = 8;
  localparam int unsigned DEF_Y_W        = 7;
  localparam int unsigned DEF_COLOUR_W   = 3;
  localparam int unsigned DEF_SCREEN_W   = 160;
  localparam int unsigned DEF_SCREEN_H   = 120;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAW
  } state_t;

  // Command payload at the default resolution.
  typedef struct packed {
    logic [DEF_X_W-1:0]      x;
    logic [DEF_Y_W-1:0]      y;
    logic [DEF_X_W-1:0]      w;
    logic [DEF_Y_W-1:0]      h;
    logic [DEF_COLOUR_W-1:0] colour;
  } cmd_t;

endpackage

// File: rtl/rect_draw_engine_if.sv
// Command queue handshake and pixel stream between the game datapath and vga_adapter.
interface rect_draw_engine_if
  import rect_draw_pkg::*;
#(
  parameter int unsigned X_W      = DEF_X_W,
  parameter int unsigned Y_W      = DEF_Y_W,
  parameter int unsigned COLOUR_W = DEF_COLOUR_W
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [X_W-1:0]      cmd_x;
  logic [Y_W-1:0]      cmd_y;
  logic [X_W-1:0]      cmd_w;
  logic [Y_W-1:0]      cmd_h;
  logic [COLOUR_W-1:0] cmd_colour;
  logic [X_W-1:0]      x_out;
  logic [Y_W-1:0]      y_out;
  logic [COLOUR_W-1:0] colour_out;
  logic                plot;
  logic                busy;
  logic                draw_done;

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour,
    input  cmd_ready, x_out, y_out, colour_out, plot, busy, draw_done
  );

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour,
    output cmd_ready, x_out, y_out, colour_out, plot, busy, draw_done
  );
endinterface

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO; depth must be a power of two so pointers wrap naturally.
module cmd_fifo
  import rect_draw_pkg::*;
#(
  parameter type         T     = cmd_t,
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  T                         din,
  input  logic                     pop,
  output T                         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; validity is tracked by cnt.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/rect_draw_engine.sv
// Queued filled-rectangle plotter: clips each command to the screen and emits one pixel per clock.
module rect_draw_engine
  import rect_draw_pkg::*;
#(
  parameter int unsigned X_W        = DEF_X_W,
  parameter int unsigned Y_W        = DEF_Y_W,
  parameter int unsigned COLOUR_W   = DEF_COLOUR_W,
  parameter int unsigned SCREEN_W   = DEF_SCREEN_W,
  parameter int unsigned SCREEN_H   = DEF_SCREEN_H,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input logic              clk,
  input logic              reset,
  rect_draw_engine_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [X_W:0] X_LIM = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(SCREEN_H);

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [X_W-1:0]      w;
    logic [Y_W-1:0]      h;
    logic [COLOUR_W-1:0] colour;
  } rect_cmd_t;

  rect_cmd_t           fifo_din, fifo_dout;
  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]    fifo_count;

  state_t              state, state_next;
  rect_cmd_t           work, work_next;
  logic [X_W-1:0]      x_last, x_last_next;
  logic [Y_W-1:0]      y_last, y_last_next;
  logic [X_W-1:0]      x_q, x_next;
  logic [Y_W-1:0]      y_q, y_next;
  logic [COLOUR_W-1:0] colour_q, colour_next;
  logic                plot_q, plot_next;
  logic                done_q, done_next;

  logic [X_W:0]        x_ext, x_room, ew;
  logic [Y_W:0]        y_ext, y_room, eh;
  logic [X_W-1:0]      x_end;
  logic [Y_W-1:0]      y_end;
  logic                discard;
  logic                last_pixel;

  assign fifo_din = '{x: bus.cmd_x, y: bus.cmd_y, w: bus.cmd_w, h: bus.cmd_h,
                      colour: bus.cmd_colour};
  assign fifo_push = bus.cmd_valid && !fifo_full;

  cmd_fifo #(
    .T     (rect_cmd_t),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Extents are one bit wider than the fields so x+w cannot wrap.
  assign x_ext   = {1'b0, work.x};
  assign y_ext   = {1'b0, work.y};
  assign x_room  = X_LIM - x_ext;
  assign y_room  = Y_LIM - y_ext;
  assign ew      = ({1'b0, work.w} > x_room) ? x_room : {1'b0, work.w};
  assign eh      = ({1'b0, work.h} > y_room) ? y_room : {1'b0, work.h};
  assign x_end   = X_W'(x_ext + ew - (X_W+1)'(1));
  assign y_end   = Y_W'(y_ext + eh - (Y_W+1)'(1));
  assign discard = (x_ext >= X_LIM) || (y_ext >= Y_LIM) ||
                   (work.w == '0) || (work.h == '0);
  assign last_pixel = (x_q == x_last) && (y_q == y_last);

  always_comb begin
    state_next  = state;
    work_next   = work;
    x_last_next = x_last;
    y_last_next = y_last;
    x_next      = x_q;
    y_next      = y_q;
    colour_next = colour_q;
    plot_next   = 1'b0;
    done_next   = 1'b0;
    fifo_pop    = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          work_next  = fifo_dout;
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (discard) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end else begin
          x_last_next = x_end;
          y_last_next = y_end;
          x_next      = work.x;
          y_next      = work.y;
          colour_next = work.colour;
          plot_next   = 1'b1;
          state_next  = DRAW;
        end
      end
      DRAW: begin
        if (last_pixel) begin
          done_next = 1'b1;
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            work_next  = fifo_dout;
            state_next = LOAD;
          end else begin
            state_next = IDLE;
          end
        end else begin
          plot_next = 1'b1;
          if (x_q == x_last) begin
            x_next = work.x;
            y_next = y_q + Y_W'(1);
          end else begin
            x_next = x_q + X_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      work     <= '0;
      x_last   <= '0;
      y_last   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_next;
      work     <= work_next;
      x_last   <= x_last_next;
      y_last   <= y_last_next;
      x_q      <= x_next;
      y_q      <= y_next;
      colour_q <= colour_next;
      plot_q   <= plot_next;
      done_q   <= done_next;
    end
  end

  assign bus.cmd_ready  = !fifo_full;
  assign bus.x_out      = x_q;
  assign bus.y_out      = y_q;
  assign bus.colour_out = colour_q;
  assign bus.plot       = plot_q;
  assign bus.draw_done  = done_q;
  assign bus.busy       = (fifo_count != '0) || (state != IDLE);
endmodule

// File: doc/rect_draw_engine.md
Name: rect_draw_engine

Overview:
- Parametrised pixel-plotting engine between game datapath and vga_adapter; replaces hand-sequenced x/y/colour/plot generation in datapath.
- Accepts queued filled-rectangle commands (pipes, hawk sprite, background clears) and emits one clipped pixel per clock in raster order.
- Resolution, colour depth and queue depth are parameters, so one block serves 160x120 3-bit and larger modes.

Parameters:
X_W, 8, width of x coordinate and rectangle width fields
Y_W, 7, width of y coordinate and rectangle height fields
COLOUR_W, 3, colour width; matches vga_adapter colour input
SCREEN_W, 160, visible columns; pixels with x >= SCREEN_W are never plotted
SCREEN_H, 120, visible rows; pixels with y >= SCREEN_H are never plotted
FIFO_DEPTH, 4, command queue entries; power of two, >= 2

Ports:
clk  in  1  system clock (CLOCK_50 at top level)
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command present on cmd_* this cycle
cmd_ready  out  1  queue can accept; equals not-full
cmd_x  in  X_W  rectangle left column
cmd_y  in  Y_W  rectangle top row
cmd_w  in  X_W  rectangle width in pixels
cmd_h  in  Y_W  rectangle height in pixels
cmd_colour  in  COLOUR_W  fill colour
x_out  out  X_W  pixel column to vga_adapter
y_out  out  Y_W  pixel row to vga_adapter
colour_out  out  COLOUR_W  pixel colour to vga_adapter
plot  out  1  pixel write strobe to vga_adapter
busy  out  1  high while queue non-empty or state != IDLE
draw_done  out  1  one-cycle pulse when a command finishes, including discarded commands

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset, taking priority over everything:
  - FIFO flushed; state IDLE.
  - plot=0, draw_done=0, x_out=0, y_out=0, colour_out=0, busy=0, cmd_ready=1 on the following cycle.
  - Reset mid-draw abandons the rectangle; no further plots.
- Handshake:
  - Command written on any edge with cmd_valid && cmd_ready.
  - cmd_valid while cmd_ready=0 is ignored and not retained.
  - cmd_ready is combinational from FIFO count.
  - A push and a pop in the same cycle are both honoured.
- FSM, three states:
  - IDLE: if FIFO non-empty, pop into working registers -> LOAD.
  - LOAD, exactly 1 cycle: compute clipped extents.
    - ew = min(w, SCREEN_W - x); eh = min(h, SCREEN_H - y).
    - If x >= SCREEN_W, y >= SCREEN_H, w == 0 or h == 0: discard, pulse draw_done, -> IDLE.
    - Otherwise -> DRAW with cx=x, cy=y.
  - DRAW: one pixel per cycle, x inner loop, y outer loop.
    - Registered outputs: x_out=cx, y_out=cy, colour_out=colour, plot=1.
    - After the last pixel (cx=x+ew-1, cy=y+eh-1): draw_done pulses on the cycle after the final plot.
    - Then -> LOAD directly if FIFO non-empty (pop), else -> IDLE.
- Latency: command accepted at edge 0 into an idle, empty engine gives the first plot visible after edge 2. The rectangle occupies exactly ew*eh consecutive plot cycles.
- Inter-command gap: 1 non-plot cycle (LOAD) between back-to-back rectangles.
- Arithmetic: extent sums computed at X_W+1 / Y_W+1 bits, so x+w never wraps. Counters never exceed SCREEN_W-1 / SCREEN_H-1.
- When not in DRAW: plot=0; x_out, y_out and colour_out hold their last values.
- Overlapping rectangles: later commands overwrite earlier ones on screen (issue order = draw order).

Decomposition:
- Package rect_draw_pkg: state enum (IDLE, LOAD, DRAW); default resolution constants; packed command struct {x, y, w, h, colour} sized from the parameters.
- One sub-module, cmd_fifo: synchronous FIFO of command structs, depth FIFO_DEPTH, with full/empty/count outputs and the same clk/reset.

Test Plan:
- Basic draw: reset, then cmd (x=10, y=20, w=3, h=2, colour=3'b100) -> first plot 2 cycles after accept; 6 plot cycles at (10,20),(11,20),(12,20),(10,21),(11,21),(12,21); draw_done pulse 1 cycle after the last; busy low afterwards.
- Clipping: cmd (x=158, y=118, w=5, h=5) -> exactly 4 plots at (158,118),(159,118),(158,119),(159,119); no x >= 160 or y >= 120 appears.
- Discard: cmd (x=160, y=0, w=4, h=4), then w=0 -> zero plots, two draw_done pulses, engine returns to IDLE.
- Back-pressure: push 6 commands (w=h=1) back-to-back with FIFO_DEPTH=4 while the first draws -> cmd_ready drops when full; only held-and-reaccepted commands are drawn, in order; exactly 1 idle cycle between plots.
- Reset mid-draw: start (0,0,16,16), assert reset at pixel 30 -> plot low the next cycle; all outputs zero; FIFO empty; a following command draws normally.
- Full-screen clear: cmd (0,0,160,120,3'b000) -> 19200 consecutive plot cycles ending at (159,119), then one draw_done pulse.
